// File: rtl/mult_div_seq.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring + sign fixup) engine for Hi/Lo.
// Optional feature: define MULTDIV_DIVZERO_EN for early divide-by-zero termination with div_zero.
module mult_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {StIdle, StMult, StDiv, StFixup, StDone} stateE;

  stateE            state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH:0]   accP;    // Booth P / division remainder
  logic [WIDTH-1:0] regQ;    // Booth multiplier / division quotient
  logic             qMinus;
  logic [WIDTH:0]   regM;    // sign-extended multiplicand or zero-extended |divisor|
  logic             aNeg;
  logic             bNeg;

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   boothSum;
  logic [WIDTH:0]   divShift;
  logic             divGe;
  logic [WIDTH:0]   divRem;
  logic [WIDTH-1:0] fixQ;
  logic [WIDTH-1:0] fixR;

  always_comb begin
    absA = a_in[WIDTH-1] ? -a_in : a_in;
    absB = b_in[WIDTH-1] ? -b_in : b_in;

    boothSum = accP;
    case ({regQ[0], qMinus})
      2'b10:   boothSum = accP - regM;
      2'b01:   boothSum = accP + regM;
      default: boothSum = accP;
    endcase

    divShift = {accP[WIDTH-1:0], regQ[WIDTH-1]};
    divGe    = (divShift >= regM);
    divRem   = divGe ? (divShift - regM) : divShift;

    // Truncating semantics: quotient sign from sign(a)^sign(b), remainder follows the dividend.
    fixQ = (aNeg ^ bNeg) ? -regQ : regQ;
    fixR = aNeg ? -accP[WIDTH-1:0] : accP[WIDTH-1:0];
  end

`ifdef MULTDIV_DIVZERO_EN
  logic dzFlag;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= StIdle;
      cnt    <= '0;
      accP   <= '0;
      regQ   <= '0;
      qMinus <= 1'b0;
      regM   <= '0;
      aNeg   <= 1'b0;
      bNeg   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef MULTDIV_DIVZERO_EN
      dzFlag   <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULTDIV_DIVZERO_EN
      div_zero <= 1'b0;
`endif
      case (state)
        StIdle: begin
          if (start) begin
            busy   <= 1'b1;
            cnt    <= CntW'(WIDTH);
            aNeg   <= a_in[WIDTH-1];
            bNeg   <= b_in[WIDTH-1];
            accP   <= '0;
            qMinus <= 1'b0;
            if (!op) begin
              regQ  <= b_in;
              regM  <= {a_in[WIDTH-1], a_in};
              state <= StMult;
            end else begin
              regQ <= absA;
              regM <= {1'b0, absB};
`ifdef MULTDIV_DIVZERO_EN
              if (b_in == '0) begin
                dzFlag <= 1'b1;
                state  <= StDone;
              end else begin
                state <= StDiv;
              end
`else
              state <= StDiv;
`endif
            end
          end
        end

        StMult: begin
          // Arithmetic right shift of {P, Q, q-1} after the add/subtract.
          accP   <= {boothSum[WIDTH], boothSum[WIDTH:1]};
          regQ   <= {boothSum[0], regQ[WIDTH-1:1]};
          qMinus <= regQ[0];
          cnt    <= cnt - 1'b1;
          if (cnt == CntW'(1)) state <= StDone;
        end

        StDiv: begin
          accP <= divRem;
          regQ <= {regQ[WIDTH-2:0], divGe};
          cnt  <= cnt - 1'b1;
          if (cnt == CntW'(1)) state <= StFixup;
        end

        StFixup: begin
          regQ  <= fixQ;
          accP  <= {1'b0, fixR};
          state <= StDone;
        end

        StDone: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= StIdle;
`ifdef MULTDIV_DIVZERO_EN
          div_zero <= dzFlag;
          dzFlag   <= 1'b0;
          if (!dzFlag) begin
            hi_out <= accP[WIDTH-1:0];
            lo_out <= regQ;
          end
`else
          hi_out <= accP[WIDTH-1:0];
          lo_out <= regQ;
`endif
        end

        default: state <= StIdle;
      endcase
    end
  end

`ifndef MULTDIV_DIVZERO_EN
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: scoreboard queue of expected Hi/Lo/latency, checked on done.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  mult_div_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a_in    (a_in),
    .b_in    (b_in),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } expT;

  expT         sb[$];
  int          nAsserts = 0;
  int          nFails = 0;
  logic [31:0] lastHi = '0;
  logic [31:0] lastLo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic expT mk(input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                             input int lat);
    expT e;
    e.hi  = hi;
    e.lo  = lo;
    e.dz  = dz;
    e.lat = lat;
    return e;
  endfunction

  // Reference model in 64-bit signed arithmetic.
  function automatic expT model(input logic o, input logic [31:0] a, input logic [31:0] b);
    expT    e;
    longint sa;
    longint sbv;
    longint p;
    longint q;
    longint r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (!o) begin
      p = sa * sbv;
      e = mk(p[63:32], p[31:0], 1'b0, 33);
    end else if (b == 32'h0) begin
`ifdef MULTDIV_DIVZERO_EN
      e = mk(lastHi, lastLo, 1'b1, 1);
`else
      e = mk(a, a[31] ? 32'h1 : 32'hFFFF_FFFF, 1'b0, 34);
`endif
    end else begin
      q = sa / sbv;
      r = sa % sbv;
      e = mk(r[31:0], q[31:0], 1'b0, 34);
    end
    return e;
  endfunction

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b, input expT e);
    sb.push_back(e);
    op    = o;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    op    = 1'($urandom_range(1));
    check("busy_rise", 64'(busy), 64'd1);
    check("done_low_at_start", 64'(done), 64'd0);
  endtask

  task automatic waitDone(input string tag, input int glitchAt);
    int  k;
    int  bc;
    expT e;
    k  = 0;
    bc = 1;
    while (k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (k == glitchAt) begin
        start = 1'b1;
        op    = 1'b0;
        a_in  = 32'd99;
        b_in  = 32'd77;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (busy) bc++;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, 64'(k), 64'(e.lat));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(e.lat));
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi_out), 64'(e.hi));
    check({tag, "_lo"}, 64'(lo_out), 64'(e.lo));
    check({tag, "_div_zero"}, 64'(div_zero), 64'(e.dz));
    lastHi = e.hi;
    lastLo = e.lo;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        ro;

    #23;
    check("reset_hi", 64'(hi_out), 64'd0);
    check("reset_lo", 64'(lo_out), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dz", 64'(div_zero), 64'd0);
    reset = 1'b0;

    issue(1'b0, 32'd7, -32'sd3, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33));
    waitDone("mul_7_m3", -1);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, mk(32'h4000_0000, 32'h0, 1'b0, 33));
    waitDone("mul_min_min", -1);
    issue(1'b0, 32'h8000_0000, 32'd1, mk(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33));
    waitDone("mul_min_1", -1);
    issue(1'b1, -32'sd7, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34));
    waitDone("div_m7_2", -1);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0, 34));
    waitDone("div_overflow", -1);
    issue(1'b1, 32'h451, 32'h20, mk(32'h11, 32'h22, 1'b0, 34));
    waitDone("div_prime", -1);
`ifdef MULTDIV_DIVZERO_EN
    issue(1'b1, 32'd5, 32'd0, mk(32'h11, 32'h22, 1'b1, 1));
`else
    issue(1'b1, 32'd5, 32'd0, mk(32'd5, 32'hFFFF_FFFF, 1'b0, 34));
`endif
    waitDone("div_zero", -1);

    issue(1'b0, 32'd1234, -32'sd5678, model(1'b0, 32'd1234, -32'sd5678));
    waitDone("mul_glitch", 10);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 5) ? 32'h0 : $urandom;
      ro = 1'(i % 2);
      issue(ro, ra, rb, model(ro, ra, rb));
      waitDone("rand", -1);
    end

    issue(1'b1, 32'd1000, 32'd7, model(1'b1, 32'd1000, 32'd7));
    repeat (12) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    void'(sb.pop_back());
    check("abort_hi", 64'(hi_out), 64'd0);
    check("abort_lo", 64'(lo_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_dz", 64'(div_zero), 64'd0);
    #1;
    reset = 1'b0;
    issue(1'b0, 32'd3, 32'd4, mk(32'h0, 32'd12, 1'b0, 33));
    waitDone("mul_after_reset", -1);

    @(posedge clk);
    #1;
    check("final_done_low", 64'(done), 64'd0);
    check("final_busy_low", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/mult_div_seq.md
# mult_div_seq

Sequential signed multiply/divide engine that serves MULT and DIV for the multicycle CPU. The control unit pulses `start` with the operation select, holds its FSM in a wait state while `busy` is high, and writes Hi/Lo on `done`. Multiplication is radix-2 Booth (32 iterations). Division is restoring on magnitudes followed by a sign-fixup cycle. Operands come from registers A/B; `hi_out`/`lo_out` feed the Hi/Lo registers.

## Interface
- `WIDTH`, default 32: operand width; iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears all state and outputs
- `start`  in  1  request; sampled only in IDLE
- `op`  in  1  0 = multiply, 1 = divide (driven from control's MultDiv)
- `a_in`  in  WIDTH  multiplicand / dividend, signed
- `b_in`  in  WIDTH  multiplier / divisor, signed
- `hi_out`  out  WIDTH  product[63:32] or remainder; registered
- `lo_out`  out  WIDTH  product[31:0] or quotient; registered
- `busy`  out  1  high in MULT, DIV, FIXUP
- `done`  out  1  one-cycle pulse; `hi_out`/`lo_out` valid; drives LoadHi/LoadLo
- `div_zero`  out  1  one-cycle pulse coincident with `done` (macro-dependent)

## Operation
- States: IDLE, MULT, DIV, FIXUP, DONE.
- IDLE → MULT or DIV on `start=1`, depending on `op`. On that edge, `a_in`/`b_in` are latched; later operand changes are ignored. The iteration counter loads `WIDTH`.
- MULT:
  - Booth register {P[WIDTH], Q[WIDTH], q-1}, arithmetic right shift each cycle.
  - Q[0],q-1 = 10 → P -= M; 01 → P += M. P is WIDTH+1 bits internally so that M = -2^31 does not overflow.
  - After `WIDTH` iterations → DONE. Hi/Lo get the full signed 64-bit product.
- DIV:
  - Restoring division on |a| and |b| (unsigned, WIDTH+1-bit remainder).
  - One quotient bit per cycle. After `WIDTH` iterations → FIXUP.
- FIXUP:
  - Quotient is negated if sign(a) ≠ sign(b).
  - Remainder takes the sign of the dividend (truncating, MIPS semantics).
  - Writes Lo = quotient, Hi = remainder → DONE.
- DONE:
  - `done=1` for exactly one cycle, then unconditional → IDLE.
  - `start` is ignored while in DONE.
- `start` while busy is ignored; no queuing.
- Overflow case: -2^31 / -1 → Lo = 0x80000000, Hi = 0. Wraps; no flag.
- Hi/Lo hold their last result until the next `done`. They are never written mid-operation.

## Timing
- Reset values: `hi_out` = 0, `lo_out` = 0, `busy` = 0, `done` = 0, `div_zero` = 0, state IDLE, counter 0.
- Start accepted at edge N:
  - `busy` rises after N.
  - Multiply: `done` and new Hi/Lo after edge N+33 (32 iterations + DONE).
  - Divide: `done` after edge N+34 (32 iterations + FIXUP + DONE).
- `busy` falls at the same edge where `done` rises.
- Earliest next accepted `start` is at edge N+34 (mult) or N+35 (div).
- `reset` asserted mid-operation:
  - Immediate abort; all outputs go to reset values.
  - No `done` is produced.
  - A `start` at the first edge after deassertion is accepted.
- Combinational path from inputs to outputs: none.

## Configuration
- `MULTDIV_DIVZERO_EN` defined:
  - Divide with `b_in` = 0 goes IDLE → DONE in one edge (`done` after N+1).
  - `div_zero=1` in the same cycle as `done`.
  - Hi/Lo are NOT written and retain their prior values.
- Undefined:
  - No detection; `div_zero` is tied 0.
  - Divide by zero runs the full 34 cycles with the natural result: Hi = a, Lo = 0xFFFFFFFF if a ≥ 0, else 0x00000001.

## Test plan
- Multiply 7 × -3 at edge N → `done` after N+33; Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB; `busy` high for exactly 33 cycles.
- Multiply 0x80000000 × 0x80000000 → Hi = 0x40000000, Lo = 0x00000000. Also 0x80000000 × 1 → Hi = 0xFFFFFFFF, Lo = 0x80000000.
- Divide -7 / 2 → `done` after N+34; Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF → Lo = 0x80000000, Hi = 0.
- Divide 5 / 0 with prior Hi/Lo = 0x11/0x22:
  - With `MULTDIV_DIVZERO_EN`: `done` and `div_zero` after N+1; Hi/Lo stay 0x11/0x22.
  - Without it: `done` after N+34; Hi = 5, Lo = 0xFFFFFFFF; `div_zero` stays 0.
- `start` pulsed at cycle 10 of a multiply with different operands → ignored; the original result is delivered at N+33 with a single `done`.
- `reset` asserted during iteration 12 of a divide → all outputs 0 asynchronously. Release, then start 3 × 4 → Hi = 0, Lo = 12 after 33 cycles.
